// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: owns the 128-bit cipher state, sequences the
// initial key add plus NR rounds through an external combinational round datapath.
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter bit ENC_DEC = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk,
  output logic [127:0] rd_state,
  output logic         rd_last,
  input  logic [127:0] rd_result,
  output logic [3:0]   round
);

  localparam logic [3:0] NR_L = 4'(NR);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state_r, state_s;
  logic [127:0] data_r, data_s;
  logic [3:0]   round_r, round_s;
  logic         out_valid_r, out_valid_s;
  logic [3:0]   rk_idx_s;

  // State register; data_r holds the captured block until INIT, then the cipher state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      data_r      <= 128'd0;
      round_r     <= 4'd0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_r      <= data_s;
      round_r     <= round_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Next-state logic: every key-consuming step waits on rk_valid, so a stall freezes everything.
  always_comb begin
    state_s     = state_r;
    data_s      = data_r;
    round_s     = round_r;
    out_valid_s = out_valid_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          data_s  = in_data;
          state_s = S_INIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INIT: begin
        if (rk_valid) begin
          data_s  = data_r ^ rk;
          round_s = 4'd1;
          state_s = S_ROUND;
        end else begin
          state_s = S_INIT;
        end
      end
      S_ROUND: begin
        if (rk_valid) begin
          data_s = rd_result;
          if (round_r == NR_L) begin
            state_s     = S_DONE;
            out_valid_s = 1'b1;
          end else begin
            round_s = round_r + 4'd1;
          end
        end else begin
          state_s = S_ROUND;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          round_s     = 4'd0;
          state_s     = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s     = S_IDLE;
        round_s     = 4'd0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Round-key index: decrypt walks the schedule backwards from NR.
  always_comb begin
    rk_idx_s = 4'd0;
    case (state_r)
      S_INIT: begin
        if (ENC_DEC) begin
          rk_idx_s = NR_L;
        end else begin
          rk_idx_s = 4'd0;
        end
      end
      S_ROUND, S_DONE: begin
        if (ENC_DEC) begin
          rk_idx_s = NR_L - round_r;
        end else begin
          rk_idx_s = round_r;
        end
      end
      default: rk_idx_s = 4'd0;
    endcase
  end

  assign in_ready  = (state_r == S_IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = data_r;
  assign rd_state  = data_r;
  assign rd_last   = (state_r == S_ROUND) && (round_r == NR_L);
  assign rk_idx    = rk_idx_s;
  assign round     = round_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: behavioural AES key schedule and round
// datapath feed the DUTs; a whole-block AES reference model supplies expected results.
module tb_aes_round_sequencer;
  localparam int NR = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         in_valid_e, in_ready_e, out_valid_e, out_ready_e, rk_valid_e, rd_last_e;
  logic [127:0] in_data_e, out_data_e, rk_e, rd_state_e, rd_result_e;
  logic [3:0]   rk_idx_e, round_e;
  logic         in_valid_d, in_ready_d, out_valid_d, out_ready_d, rk_valid_d, rd_last_d;
  logic [127:0] in_data_d, out_data_d, rk_d, rd_state_d, rd_result_d;
  logic [3:0]   rk_idx_d, round_d;

  logic [127:0] rk_tab [0:15];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- GF(2^8) and AES primitives ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      if (!inv) begin
        o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end else begin
        o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return o;
  endfunction

  // One round as the external datapath computes it
  function automatic logic [127:0] dp_round(input logic [127:0] s, input logic [127:0] k,
                                            input logic last, input bit inv);
    logic [127:0] t;
    if (!inv) begin
      t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (!last) t = mix_cols(t, 1'b0);
      return t ^ k;
    end
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    if (!last) t = mix_cols(t, 1'b1);
    return t;
  endfunction

  // Whole-block references
  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r <= NR; r++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (r < NR) s = mix_cols(s, 1'b0);
      s = s ^ rk_tab[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk_tab[NR];
    for (int r = NR - 1; r >= 0; r--) begin
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_tab[r];
      if (r > 0) s = mix_cols(s, 1'b1);
    end
    return s;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- DUTs and their behavioural environment ----------------
  assign rk_e        = rk_tab[rk_idx_e];
  assign rd_result_e = dp_round(rd_state_e, rk_e, rd_last_e, 1'b0);
  assign rk_d        = rk_tab[rk_idx_d];
  assign rd_result_d = dp_round(rd_state_d, rk_d, rd_last_d, 1'b1);

  aes_round_sequencer #(.NR(NR), .ENC_DEC(1'b0)) u_enc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_e), .in_ready(in_ready_e), .in_data(in_data_e),
    .out_valid(out_valid_e), .out_ready(out_ready_e), .out_data(out_data_e),
    .rk_idx(rk_idx_e), .rk_valid(rk_valid_e), .rk(rk_e),
    .rd_state(rd_state_e), .rd_last(rd_last_e), .rd_result(rd_result_e),
    .round(round_e)
  );

  aes_round_sequencer #(.NR(NR), .ENC_DEC(1'b1)) u_dec (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d),
    .rk_idx(rk_idx_d), .rk_valid(rk_valid_d), .rk(rk_d),
    .rd_state(rd_state_d), .rd_last(rd_last_d), .rd_result(rd_result_d),
    .round(round_d)
  );

  // ---------------- checking and sequencing helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_e(input logic [127:0] pt);
    int n;
    n = 0;
    while (!in_ready_e && n < 40) begin
      tick();
      n++;
    end
    check("accept_wait", 128'(in_ready_e), 128'(1'b1));
    in_valid_e = 1'b1;
    in_data_e  = pt;
    tick();
    in_valid_e = 1'b0;
    check("in_ready_after_accept", 128'(in_ready_e), 128'(1'b0));
  endtask

  // Counts edges after the accepting edge; round r is expected after r unstalled edges.
  task automatic wait_out_e(input logic [127:0] exp, input int stall_at, input int stall_len);
    int n, er;
    bit stalled;
    logic [127:0] frozen;
    n = 0; stalled = 1'b0;
    while (!out_valid_e && n < 60) begin
      if (!stalled && stall_len > 0 && round_e == 4'(stall_at)) begin
        stalled = 1'b1;
        frozen  = out_data_e;
        rk_valid_e = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          n++;
          check("stall_round", 128'(round_e), 128'(stall_at));
          check("stall_state", out_data_e, frozen);
        end
        rk_valid_e = 1'b1;
      end else begin
        er = stalled ? n - stall_len : n;
        check("round", 128'(round_e), 128'(er));
        check("rk_idx_enc", 128'(rk_idx_e), 128'(er));
        check("rd_last", 128'(rd_last_e), 128'(er == NR));
        tick();
        n++;
      end
    end
    check("out_valid_rise", 128'(out_valid_e), 128'(1'b1));
    check("latency", 128'(n), 128'(NR + 1 + stall_len));
    check("result_enc", out_data_e, exp);
  endtask

  task automatic handshake_e(input int hold);
    logic [127:0] held;
    held = out_data_e;
    out_ready_e = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      check("hold_valid", 128'(out_valid_e), 128'(1'b1));
      check("hold_in_ready", 128'(in_ready_e), 128'(1'b0));
      check("hold_data", out_data_e, held);
    end
    out_ready_e = 1'b1;
    tick();
    out_ready_e = 1'b0;
    check("valid_after_hs", 128'(out_valid_e), 128'(1'b0));
    check("in_ready_after_hs", 128'(in_ready_e), 128'(1'b1));
  endtask

  task automatic dec_block(input logic [127:0] ct, input logic [127:0] exp);
    check("dec_in_ready", 128'(in_ready_d), 128'(1'b1));
    in_valid_d = 1'b1;
    in_data_d  = ct;
    tick();
    in_valid_d = 1'b0;
    check("dec_rk_idx_init", 128'(rk_idx_d), 128'(NR));
    for (int r = 1; r <= NR; r++) begin
      tick();
      check("dec_round", 128'(round_d), 128'(r));
      check("dec_rk_idx", 128'(rk_idx_d), 128'(NR - r));
      check("dec_rd_last", 128'(rd_last_d), 128'(r == NR));
    end
    tick();
    check("dec_out_valid", 128'(out_valid_d), 128'(1'b1));
    check("result_dec", out_data_d, exp);
    out_ready_d = 1'b1;
    tick();
    out_ready_d = 1'b0;
    check("dec_valid_after_hs", 128'(out_valid_d), 128'(1'b0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] pt, pt2;
    logic [127:0] q [$];
    int cyc, last_acc, acc, res, guard;
    bit seen;

    expand_key(KAT_KEY);
    rst_n = 1'b0;
    in_valid_e = 1'b0; in_data_e = 128'd0; out_ready_e = 1'b0; rk_valid_e = 1'b1;
    in_valid_d = 1'b0; in_data_d = 128'd0; out_ready_d = 1'b0; rk_valid_d = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 128'(out_valid_e), 128'(1'b0));
    check("rst_round", 128'(round_e), 128'(0));
    check("rst_rk_idx", 128'(rk_idx_e), 128'(0));
    check("rst_rd_last", 128'(rd_last_e), 128'(1'b0));
    check("rst_state", out_data_e, 128'd0);
    check("rst_dec_rk_idx", 128'(rk_idx_d), 128'(0));
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", 128'(in_ready_e), 128'(1'b1));

    // Known-answer encrypt and decrypt
    accept_e(KAT_PT);
    wait_out_e(KAT_CT, 0, 0);
    handshake_e(0);
    dec_block(KAT_CT, KAT_PT);

    // Key stall of 3 cycles at round 5
    accept_e(KAT_PT);
    wait_out_e(KAT_CT, 5, 3);
    handshake_e(0);

    // Backpressure with a second block waiting
    pt2 = rand128();
    accept_e(KAT_PT);
    wait_out_e(KAT_CT, 0, 0);
    in_valid_e = 1'b1;
    in_data_e  = pt2;
    handshake_e(5);
    tick();
    in_valid_e = 1'b0;
    check("second_accepted", 128'(in_ready_e), 128'(1'b0));
    wait_out_e(ref_enc(pt2), 0, 0);
    handshake_e(0);

    // Reset in the middle of a block
    accept_e(rand128());
    guard = 0;
    while (round_e != 4'd4 && guard < 30) begin
      tick();
      guard++;
    end
    check("reach_round4", 128'(round_e), 128'(4));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 128'(in_ready_e), 128'(1'b1));
    check("midrst_round", 128'(round_e), 128'(0));
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid_e) seen = 1'b1;
      tick();
    end
    check("midrst_no_valid", 128'(seen), 128'(1'b0));
    pt = rand128();
    accept_e(pt);
    wait_out_e(ref_enc(pt), 0, 0);
    handshake_e(0);

    // Random key, random blocks, random stalls and backpressure
    expand_key(rand128());
    for (int i = 0; i < 6; i++) begin
      pt = rand128();
      accept_e(pt);
      wait_out_e(ref_enc(pt), int'($urandom_range(1, NR)), int'($urandom_range(0, 3)));
      handshake_e(int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 3; i++) begin
      pt = rand128();
      dec_block(pt, ref_dec(pt));
    end

    // Back-to-back stream of 4 blocks
    in_valid_e = 1'b1;
    out_ready_e = 1'b1;
    in_data_e = rand128();
    cyc = 0; last_acc = -1; acc = 0; res = 0;
    while (res < 4 && cyc < 200) begin
      if (in_valid_e && in_ready_e) begin
        q.push_back(ref_enc(in_data_e));
        if (last_acc >= 0) check("b2b_interval", 128'(cyc - last_acc), 128'(NR + 3));
        last_acc = cyc;
        acc++;
        tick();
        cyc++;
        if (acc < 4) in_data_e = rand128();
        else in_valid_e = 1'b0;
      end else begin
        tick();
        cyc++;
      end
      if (out_valid_e) begin
        if (q.size() > 0) check("b2b_result", out_data_e, q.pop_front());
        else check("b2b_unexpected", 128'(out_valid_e), 128'(1'b0));
        res++;
      end
    end
    check("b2b_count", 128'(res), 128'(4));
    tick();
    out_ready_e = 1'b0;
    in_valid_e  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
